// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: request/ack data bus with wait states, misaligned accesses split into two beats.
// Build option: LSU_MISALIGN_TRAP_EN makes any misaligned access respond with resp_err and no bus traffic.
module lsu_mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata
);
  localparam int BE_W  = DATA_W / 8;
  localparam int BE2   = 2 * BE_W;
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
  state_t state, stateNext;

  logic              accept;
  logic              reqErr;
  logic              storeQ;
  logic [2:0]        funct3Q;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic [DATA_W-1:0] loQ;
  logic [DATA_W-1:0] hiQ;
  logic              errQ;

  function automatic logic isLegal(input logic store, input logic [2:0] f3);
    logic wide;
    wide = (DATA_W == 64);
    if (store)
      return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) || (wide && (f3 == 3'b011));
    else
      return (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
             (wide && ((f3 == 3'b011) || (f3 == 3'b110)));
  endfunction

  assign accept = req_valid & req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  logic [OFF_W-1:0] reqOff;
  logic [3:0]       reqSize;
  assign reqOff  = req_addr[OFF_W-1:0];
  assign reqSize = 4'd1 << req_funct3[1:0];
  assign reqErr  = ~isLegal(req_store, req_funct3) | (|(reqOff & OFF_W'(reqSize - 4'd1)));
`else
  assign reqErr  = ~isLegal(req_store, req_funct3);
`endif

  logic [OFF_W-1:0]  offQ;
  logic [3:0]        sizeQ;
  logic [4:0]        spanQ;
  logic              split;
  logic [OFF_W+2:0]  byteSh;
  logic [BE2-1:0]    sizeMask;
  logic [BE2-1:0]    laneMask;
  logic [ADDR_W-1:0] alignedAddr;
  logic [DATA_W-1:0] rotWdata;

  assign offQ        = addrQ[OFF_W-1:0];
  assign sizeQ       = 4'd1 << funct3Q[1:0];
  assign spanQ       = 5'(offQ) + 5'(sizeQ);
  assign split       = spanQ > 5'(BE_W);
  assign byteSh      = {offQ, 3'b000};
  assign sizeMask    = (BE2'(1) << sizeQ) - BE2'(1);
  // Low half of the shifted mask covers beat 0, high half the spill-over lanes of beat 1.
  assign laneMask    = sizeMask << offQ;
  assign alignedAddr = {addrQ[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign rotWdata    = (wdataQ << byteSh) | (wdataQ >> (DATA_W - int'(byteSh)));

  logic [DATA_W-1:0] loadRaw;
  logic [DATA_W-1:0] keepMask;
  logic [DATA_W-1:0] loadExt;
  logic              signBit;
  int unsigned       nBits;

  assign nBits    = 32'(sizeQ) << 3;
  assign loadRaw  = DATA_W'({hiQ, loQ} >> byteSh);
  assign keepMask = {DATA_W{1'b1}} >> (DATA_W - nBits);
  assign signBit  = ~funct3Q[2] & loadRaw[IDX_W'(nBits - 1)];
  assign loadExt  = (loadRaw & keepMask) | ({DATA_W{signBit}} & ~keepMask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (req_valid) stateNext = reqErr ? RESP : BEAT0;
      BEAT0:   if (bus_ack) stateNext = split ? BEAT1 : RESP;
      BEAT1:   if (bus_ack) stateNext = RESP;
      RESP:    if (req_valid) stateNext = reqErr ? RESP : BEAT0;
               else stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      storeQ  <= 1'b0;
      funct3Q <= '0;
      addrQ   <= '0;
      wdataQ  <= '0;
      loQ     <= '0;
      hiQ     <= '0;
      errQ    <= 1'b0;
    end else begin
      if (accept) begin
        storeQ  <= req_store;
        funct3Q <= req_funct3;
        addrQ   <= req_addr;
        wdataQ  <= req_wdata;
        errQ    <= reqErr;
        loQ     <= '0;
        hiQ     <= '0;
      end
      if ((state == BEAT0) && bus_ack) loQ <= bus_rdata;
      if ((state == BEAT1) && bus_ack) hiQ <= bus_rdata;
    end
  end

  assign req_ready  = (state == IDLE) || (state == RESP);
  assign bus_req    = (state == BEAT0) || (state == BEAT1);
  assign bus_we     = bus_req & storeQ;
  assign bus_addr   = (state == BEAT0) ? alignedAddr :
                      (state == BEAT1) ? alignedAddr + ADDR_W'(BE_W) : '0;
  assign bus_be     = (state == BEAT0) ? laneMask[BE_W-1:0] :
                      (state == BEAT1) ? laneMask[BE2-1:BE_W] : '0;
  assign bus_wdata  = bus_req ? rotWdata : '0;
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid & errQ;
  assign resp_rdata = (resp_valid & ~errQ & ~storeQ) ? loadExt : '0;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage (DATA_W=32): byte-memory reference model plus a wait-state bus responder.
module tb_lsu_mem_stage;
  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  lsu_mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nChecks = 0;
  int nBad = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bus-side memory (written only through the DUT) and the reference memory (written by the model).
  logic [7:0] busMem [logic [31:0]];
  logic [7:0] refMem [logic [31:0]];

  function automatic logic [7:0] initByte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction
  function automatic logic [7:0] rdBus(input logic [31:0] a);
    return busMem.exists(a) ? busMem[a] : initByte(a);
  endfunction
  function automatic logic [7:0] rdRef(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : initByte(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    for (int k = 0; k < 4; k++) begin
      busMem[a + 32'(k)] = v[8*k +: 8];
      refMem[a + 32'(k)] = v[8*k +: 8];
    end
  endtask

  function automatic logic isLegal32(input logic st, input logic [2:0] f3);
    return st ? (f3 < 3'd3) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
  endfunction

  function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int n;
    v = '0;
    n = 1 << f3[1:0];
    for (int k = 0; k < n; k++) v[8*k +: 8] = rdRef(a + 32'(k));
    if (!f3[2] && v[8*n-1])
      for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
    return v;
  endfunction

  task automatic refStore(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 1 << f3[1:0];
    for (int k = 0; k < n; k++) refMem[a + 32'(k)] = wd[8*k +: 8];
  endtask

  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        we;
  } beat_t;
  beat_t beatLog[$];
  int beatCount = 0;
  int waitCfg = 0;

  // Acks each bus beat after waitCfg wait cycles; outside beats it toggles ack randomly.
  initial begin : responder
    int waited;
    logic [31:0] holdAddr;
    logic [3:0]  holdBe;
    logic        holdWe;
    logic [31:0] holdWd;
    waited = 0;
    bus_ack = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      bus_rdata = '0;
      if (rst_n && bus_req) begin
        if (waited == 0) begin
          holdAddr = bus_addr; holdBe = bus_be; holdWe = bus_we; holdWd = bus_wdata;
        end else begin
          checkVal("holdAddr", bus_addr, holdAddr);
          checkVal("holdBe", bus_be, holdBe);
          checkVal("holdWe", bus_we, holdWe);
          checkVal("holdWdata", bus_wdata, holdWd);
        end
        if (waited < waitCfg) waited++;
        else begin
          waited = 0;
          bus_ack = 1'b1;
          beatCount++;
          beatLog.push_back('{a: bus_addr, be: bus_be, wd: bus_wdata, we: bus_we});
          for (int k = 0; k < 4; k++) begin
            bus_rdata[8*k +: 8] = rdBus(bus_addr + 32'(k));
            if (bus_we && bus_be[k]) busMem[bus_addr + 32'(k)] = bus_wdata[8*k +: 8];
          end
        end
      end else begin
        waited = 0;
        bus_ack = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
      end
    end
  end

  task automatic runReq(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int waits);
    int n, off, beatsExp, latExp, cyc, beats0;
    logic errExp;
    logic [31:0] dataExp;
    n = 1 << f3[1:0];
    off = int'(a[1:0]);
    errExp = !isLegal32(st, f3);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((off % n) != 0) errExp = 1'b1;
`endif
    beatsExp = errExp ? 0 : ((off + n > 4) ? 2 : 1);
    latExp = errExp ? 1 : 1 + beatsExp * (waits + 1);
    dataExp = (errExp || st) ? 32'h0 : refLoad(f3, a);
    if (!errExp && st) refStore(f3, a, wd);
    waitCfg = waits;
    beats0 = beatCount;
    checkVal("reqReady", req_ready, 1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 40) begin
      checkVal("stallReady", req_ready, 0);
      checkVal("busReq", bus_req, 1);
      @(posedge clk); #1;
      cyc++;
    end
    checkVal("latency", cyc, latExp);
    checkVal("respErr", resp_err, errExp);
    checkVal("respData", resp_rdata, dataExp);
    checkVal("beats", beatCount - beats0, beatsExp);
    if (st && !errExp)
      for (int k = 0; k < n; k++) checkVal("memByte", rdBus(a + 32'(k)), rdRef(a + 32'(k)));
  endtask

  initial begin : driver
    int cyc, b0, gap;
    rst_n = 1'b0;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    #12;
    checkVal("rstReady", req_ready, 1);
    checkVal("rstRespValid", resp_valid, 0);
    checkVal("rstRespErr", resp_err, 0);
    checkVal("rstRespData", resp_rdata, 0);
    checkVal("rstBusReq", bus_req, 0);
    checkVal("rstBusWe", bus_we, 0);
    checkVal("rstBusAddr", bus_addr, 0);
    checkVal("rstBusBe", bus_be, 0);
    checkVal("rstBusWdata", bus_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    beatLog.delete();
    runReq(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0);
    checkVal("swLog", beatLog.size(), 1);
    if (beatLog.size() == 1) begin
      checkVal("swAddr", beatLog[0].a, 32'h100);
      checkVal("swBe", beatLog[0].be, 4'b1111);
      checkVal("swWdata", beatLog[0].wd, 32'hDEAD_BEEF);
      checkVal("swWe", beatLog[0].we, 1);
    end
    repeat (2) @(negedge clk);

    preload(32'h100, 32'h8011_2233);
    runReq(1'b0, 3'b000, 32'h103, 32'h0, 0);
    checkVal("lbData", resp_rdata, 32'hFFFF_FF80);
    @(negedge clk);
    runReq(1'b0, 3'b100, 32'h103, 32'h0, 1);
    checkVal("lbuData", resp_rdata, 32'h0000_0080);
    repeat (2) @(negedge clk);

`ifndef LSU_MISALIGN_TRAP_EN
    beatLog.delete();
    runReq(1'b1, 3'b001, 32'h103, 32'h0000_ABCD, 0);
    checkVal("shLog", beatLog.size(), 2);
    if (beatLog.size() == 2) begin
      checkVal("shAddr0", beatLog[0].a, 32'h100);
      checkVal("shBe0", beatLog[0].be, 4'b1000);
      checkVal("shWdata0", beatLog[0].wd, 32'hCD00_00AB);
      checkVal("shAddr1", beatLog[1].a, 32'h104);
      checkVal("shBe1", beatLog[1].be, 4'b0001);
      checkVal("shWdata1", beatLog[1].wd, 32'hCD00_00AB);
    end
    repeat (2) @(negedge clk);
`endif

    preload(32'h100, 32'h4433_2211);
    preload(32'h104, 32'h8877_6655);
    runReq(1'b0, 3'b010, 32'h102, 32'h0, 0);
`ifndef LSU_MISALIGN_TRAP_EN
    checkVal("lwSplitData", resp_rdata, 32'h6655_4433);
`endif
    repeat (2) @(negedge clk);

    runReq(1'b0, 3'b010, 32'h200, 32'h0, 3);
    runReq(1'b1, 3'b000, 32'h201, 32'h0000_005A, 0);
    runReq(1'b0, 3'b111, 32'h100, 32'h0, 0);
    runReq(1'b1, 3'b011, 32'h100, 32'h0, 0);
    repeat (2) @(negedge clk);

`ifndef LSU_MISALIGN_TRAP_EN
    beatLog.delete();
    runReq(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 1);
    if (beatLog.size() == 2) checkVal("wrapAddr1", beatLog[1].a, 32'h0);
    else checkVal("wrapLog", beatLog.size(), 2);
    repeat (2) @(negedge clk);

    b0 = beatCount;
    waitCfg = 2;
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h102; req_wdata = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0;
    while (beatCount == b0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkVal("rstBeat0Done", beatCount - b0, 1);
    @(negedge clk);
    checkVal("beat1Req", bus_req, 1);
    rst_n = 1'b0;
    #1;
    checkVal("midRstBusReq", bus_req, 0);
    checkVal("midRstReady", req_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkVal("rstNoResp", resp_valid, 0);
      checkVal("rstNoBus", bus_req, 0);
    end
`endif

    for (int it = 0; it < 150; it++) begin
      logic st;
      logic [2:0] f3;
      logic [31:0] a;
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      else a = 32'h100 + 32'($urandom_range(0, 23));
      runReq(st, f3, a, $urandom, int'($urandom_range(0, 2)));
      gap = int'($urandom_range(0, 2));
      if (gap == 2) begin
        @(negedge clk);
        @(negedge clk);
        checkVal("respPulse", resp_valid, 0);
      end else if (gap == 1) begin
        @(negedge clk);
      end
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end
endmodule
